// File: rtl/seq_alu.sv
// Registered valid/ready ALU: ADD/SUB/AND/XOR/SLL/SRL/SRA with carry, sign, overflow and zero flags.
// Define SEQ_ALU_MUL_EN to enable the iterative unsigned shift-add MUL on opcode 111.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] operand0,
  input  logic [WIDTH-1:0] operand1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] result_hi,
  output logic             carryflag,
  output logic             signflag,
  output logic             overflowflag,
  output logic             zflag,
  output logic             illegal
);

  localparam int M = WIDTH - 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic             c_q, c_d, s_q, s_d, v_q, v_d, z_q, z_d, ill_q, ill_d;

  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

  assign add_w = {1'b0, operand0} + {1'b0, operand1};
  assign sub_w = {1'b0, operand0} - {1'b0, operand1};
  assign shamt = operand1[SHW-1:0];

`ifdef SEQ_ALU_MUL_EN
  localparam logic [1:0] S_BUSY = 2'd1;
  logic [WIDTH-1:0] mcand_q, mcand_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, cnt_q, cnt_d;
  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] step_hi, step_lo;

  // Multiplier sits in the low half of the accumulator and is consumed LSB-first.
  assign psum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
  assign step_hi = psum[WIDTH:1];
  assign step_lo = {psum[0], acc_lo_q[WIDTH-1:1]};
`endif

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      3'b000: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (operand0[M] == operand1[M]) && (add_w[M] != operand0[M]);
      end
      3'b001: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = ~sub_w[WIDTH];
        alu_v   = (operand0[M] != operand1[M]) && (sub_w[M] != operand0[M]);
      end
      3'b010: alu_res = operand0 & operand1;
      3'b011: alu_res = operand0 ^ operand1;
      3'b100: alu_res = operand0 << shamt;
      3'b101: alu_res = operand0 >> shamt;
      3'b110: alu_res = $signed(operand0) >>> shamt;
      default: begin
`ifndef SEQ_ALU_MUL_EN
        alu_ill = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    c_d     = c_q;
    s_d     = s_q;
    v_d     = v_q;
    z_d     = z_q;
    ill_d   = ill_q;
`ifdef SEQ_ALU_MUL_EN
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
          if (alu_control == 3'b111) begin
            mcand_d  = operand0;
            acc_hi_d = '0;
            acc_lo_d = operand1;
            cnt_d    = WIDTH'(WIDTH - 1);
            state_d  = S_BUSY;
          end else
`endif
          begin
            res_d   = alu_res;
            hi_d    = '0;
            c_d     = alu_c;
            v_d     = alu_v;
            s_d     = alu_res[M];
            z_d     = (alu_res == '0);
            ill_d   = alu_ill;
            state_d = S_DONE;
          end
        end
      end
`ifdef SEQ_ALU_MUL_EN
      S_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - WIDTH'(1);
        // The last step writes straight into the output registers.
        if (cnt_q == '0) begin
          res_d   = step_lo;
          hi_d    = step_hi;
          c_d     = 1'b0;
          v_d     = (step_hi != '0);
          s_d     = step_lo[M];
          z_d     = (step_lo == '0);
          ill_d   = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      c_q     <= c_d;
      s_q     <= s_d;
      v_q     <= v_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
`ifdef SEQ_ALU_MUL_EN
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign ALUResult    = res_q;
  assign result_hi    = hi_q;
  assign carryflag    = c_q;
  assign signflag     = s_q;
  assign overflowflag = v_q;
  assign zflag        = z_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit and an 8-bit instance share clock and reset.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        iv_a, ord_a, ird_a, ov_a, c_a, s_a, v_a, z_a, ill_a;
  logic [2:0]  op_a;
  logic [31:0] a0_a, a1_a, res_a, hi_a;

  logic        iv_b, ord_b, ird_b, ov_b, c_b, s_b, v_b, z_b, ill_b;
  logic [2:0]  op_b;
  logic [7:0]  a0_b, a1_b, res_b, hi_b;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ird_a), .alu_control(op_a),
    .operand0(a0_a), .operand1(a1_a), .out_valid(ov_a), .out_ready(ord_a),
    .ALUResult(res_a), .result_hi(hi_a), .carryflag(c_a), .signflag(s_a),
    .overflowflag(v_a), .zflag(z_a), .illegal(ill_a)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ird_b), .alu_control(op_b),
    .operand0(a0_b), .operand1(a1_b), .out_valid(ov_b), .out_ready(ord_b),
    .ALUResult(res_b), .result_hi(hi_b), .carryflag(c_b), .signflag(s_b),
    .overflowflag(v_b), .zflag(z_b), .illegal(ill_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      iv_b = v; op_b = op; a0_b = a[7:0]; a1_b = b[7:0];
    end else begin
      iv_a = v; op_a = op; a0_a = a; a1_a = b;
    end
  endtask

  task automatic set_ordy(input bit w8, input logic r);
    if (w8) ord_b = r;
    else    ord_a = r;
  endtask

  function automatic logic [31:0] get_res(input bit w8);
    return w8 ? {24'h0, res_b} : res_a;
  endfunction

  function automatic logic [31:0] get_hi(input bit w8);
    return w8 ? {24'h0, hi_b} : hi_a;
  endfunction

  // {in_ready, out_valid, carry, sign, overflow, zero, illegal}
  function automatic logic [6:0] get_flags(input bit w8);
    return w8 ? {ird_b, ov_b, c_b, s_b, v_b, z_b, ill_b}
              : {ird_a, ov_a, c_a, s_a, v_a, z_a, ill_a};
  endfunction

  // One full transaction: accept, wait for out_valid, optionally stall the consumer, hand off.
  task automatic xact(input string name, input bit w8, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                      input int stall, input logic [31:0] er, input logic [31:0] eh,
                      input logic ec, input logic es, input logic ev, input logic ez,
                      input logic eil);
    logic [6:0] f;
    int lat;
    @(negedge clk);
    f = get_flags(w8);
    check({name, ":in_ready"}, f[6], 1'b1);
    drive(w8, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w8, 1'b0, 3'b000, 32'h0, 32'h0);
    lat = 1;
    f = get_flags(w8);
    check({name, ":busy_rdy"}, f[6], 1'b0);
    while (!f[5] && lat < exp_lat + 4) begin
      @(posedge clk); #1;
      lat++;
      f = get_flags(w8);
    end
    check({name, ":latency"}, lat, exp_lat);
    check({name, ":res"}, get_res(w8), er);
    check({name, ":hi"}, get_hi(w8), eh);
    check({name, ":flags"}, f[4:0], {ec, es, ev, ez, eil});
    for (int i = 0; i < stall; i++) begin
      drive(w8, 1'b1, 3'b000, 32'h1, 32'h1);
      @(posedge clk); #1;
      f = get_flags(w8);
      check({name, ":stall_res"}, get_res(w8), er);
      check({name, ":stall_vr"}, f[6:5], 2'b01);
    end
    drive(w8, 1'b0, 3'b000, 32'h0, 32'h0);
    set_ordy(w8, 1'b1);
    @(posedge clk); #1;
    set_ordy(w8, 1'b0);
    f = get_flags(w8);
    check({name, ":handoff"}, f[6:5], 2'b10);
    check({name, ":held_res"}, get_res(w8), er);
    $display("%s w%0d op=%0d a=0x%0h b=0x%0h res=0x%0h hi=0x%0h flags=%b lat=%0d",
             name, w8 ? 8 : 32, op, a, b, get_res(w8), get_hi(w8), f[4:0], lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] f;
    bit seen;
    ord_a = 1'b0; ord_b = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 32'h1234, 32'h1);
    drive(1'b1, 1'b1, 3'b000, 32'h12, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      f = get_flags(w[0]);
      check("reset:res", get_res(w[0]), 32'h0);
      check("reset:hi", get_hi(w[0]), 32'h0);
      check("reset:vflags", f[5:0], 6'h0);
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset:rdy32", {ird_a, ov_a}, 2'b10);
    check("reset:rdy8", {ird_b, ov_b}, 2'b10);
    $display("reset released");

    //      name        w8  op      a             b        lat st  res           hi     c  s  v  z  il
    xact("add_ovf",   0, 3'b000, 32'h7FFFFFFF, 32'h1,        1, 0, 32'h80000000, 32'h0, 0, 1, 1, 0, 0);
    xact("sub_eq",    0, 3'b001, 32'h5,        32'h5,        1, 0, 32'h0,        32'h0, 1, 0, 0, 1, 0);
    xact("sub_brw",   0, 3'b001, 32'h3,        32'h5,        1, 0, 32'hFFFFFFFE, 32'h0, 0, 1, 0, 0, 0);
    xact("add_cry",   0, 3'b000, 32'hFFFFFFFF, 32'h1,        1, 0, 32'h0,        32'h0, 1, 0, 0, 1, 0);
    xact("sub_ovf",   0, 3'b001, 32'h80000000, 32'h1,        1, 0, 32'h7FFFFFFF, 32'h0, 1, 0, 1, 0, 0);
    xact("and",       0, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 1, 0, 32'hF000F000, 32'h0, 0, 1, 0, 0, 0);
    xact("xor",       0, 3'b011, 32'hAAAA5555, 32'hFFFF0000, 1, 0, 32'h55555555, 32'h0, 0, 0, 0, 0, 0);
    xact("sll31",     0, 3'b100, 32'h1,        32'h3F,       1, 0, 32'h80000000, 32'h0, 0, 1, 0, 0, 0);
    xact("srl4",      0, 3'b101, 32'h80000000, 32'h24,       1, 0, 32'h08000000, 32'h0, 0, 0, 0, 0, 0);
    xact("sra4_bp",   0, 3'b110, 32'h80000000, 32'h24,       1, 5, 32'hF8000000, 32'h0, 0, 1, 0, 0, 0);
    xact("sra0",      0, 3'b110, 32'h7FFFFFFF, 32'h20,       1, 0, 32'h7FFFFFFF, 32'h0, 0, 0, 0, 0, 0);
    xact("add8_ovf",  1, 3'b000, 32'h7F,       32'h1,        1, 0, 32'h80,       32'h0, 0, 1, 1, 0, 0);
    xact("sub8_brw",  1, 3'b001, 32'h0,        32'h1,        1, 0, 32'hFF,       32'h0, 0, 1, 0, 0, 0);
    xact("sra8_3",    1, 3'b110, 32'h80,       32'hFB,       1, 0, 32'hF0,       32'h0, 0, 1, 0, 0, 0);
`ifdef SEQ_ALU_MUL_EN
    xact("mul8_ff",   1, 3'b111, 32'hFF,       32'hFF,       9, 0, 32'h01,       32'hFE, 0, 0, 1, 0, 0);
    xact("mul8_small",1, 3'b111, 32'h0F,       32'h03,       9, 0, 32'h2D,       32'h0, 0, 0, 0, 0, 0);
    xact("mul32",     0, 3'b111, 32'h10000,    32'h10000,   33, 0, 32'h0,        32'h1, 0, 0, 1, 1, 0);

    // Reset during the fourth BUSY cycle must abort the multiply.
    @(negedge clk);
    drive(1'b1, 1'b1, 3'b111, 32'hFF, 32'hFF);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ov_b) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("mulrst:no_valid", seen, 1'b0);
    check("mulrst:idle", {ird_b, ov_b}, 2'b10);
    check("mulrst:res", get_res(1'b1), 32'h0);
    $display("mul reset abort seen_valid=%0d in_ready=%0d", seen, ird_b);
`else
    xact("mul_ill32", 0, 3'b111, 32'hFF,       32'hFF,       1, 0, 32'h0,        32'h0, 0, 0, 0, 1, 1);
    xact("mul_ill8",  1, 3'b111, 32'hFF,       32'hFF,       1, 0, 32'h0,        32'h0, 0, 0, 0, 1, 1);
    xact("add_clr",   0, 3'b000, 32'h2,        32'h3,        1, 0, 32'h5,        32'h0, 0, 0, 0, 0, 0);
`endif

    // Reset while holding a result in DONE drops it.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'b000, 32'h2, 32'h3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("donerst:valid", ov_a, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    f = get_flags(1'b0);
    check("donerst:flags", f[5:0], 6'h0);
    check("donerst:res", get_res(1'b0), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("donerst:rdy", ird_a, 1'b1);
    $display("done reset abort out_valid=%0d res=0x%0h", ov_a, res_a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
